// File: rtl/frame_timing_pkg.sv
// frame_timing_pkg: timing types, preset modes, FSM states and bus packing for frame_timing_ctrl
package frame_timing_pkg;
  typedef struct packed {
    logic [10:0] width;
    logic [10:0] height;
    logic [8:0]  h_front;
    logic [8:0]  h_sync;
    logic [8:0]  h_back;
    logic [5:0]  v_front;
    logic [5:0]  v_sync;
    logic [7:0]  v_back;
  } timing_t;
  typedef struct packed {
    logic [21:0] res;
    logic [31:0] front;
    logic [31:0] back;
    logic [31:0] sync;
  } bus_t;
  typedef enum logic [1:0] {IDLE, WAIT_VS, HOLD, SETTLE} state_t;
  localparam timing_t MODE_640X480 = '{width: 11'd640, height: 11'd480, h_front: 9'd16, h_sync: 9'd96,
    h_back: 9'd48, v_front: 6'd10, v_sync: 6'd2, v_back: 8'd33};
  localparam timing_t MODE_800X600 = '{width: 11'd800, height: 11'd600, h_front: 9'd40, h_sync: 9'd128,
    h_back: 9'd88, v_front: 6'd1, v_sync: 6'd4, v_back: 8'd23};
  localparam timing_t MODE_1024X768 = '{width: 11'd1024, height: 11'd768, h_front: 9'd24, h_sync: 9'd136,
    h_back: 9'd160, v_front: 6'd3, v_sync: 6'd6, v_back: 8'd29};
  localparam timing_t MODE_1280X1024 = '{width: 11'd1280, height: 11'd1024, h_front: 9'd48, h_sync: 9'd112,
    h_back: 9'd248, v_front: 6'd1, v_sync: 6'd3, v_back: 8'd38};
  function automatic bus_t pack_timing(input timing_t t);
    return '{res: {t.width, t.height},
             front: {7'd0, t.h_front, 10'd0, t.v_front},
             back: {7'd0, t.h_back, 8'd0, t.v_back},
             sync: {7'd0, t.h_sync, 10'd0, t.v_sync}};
  endfunction
endpackage

// File: rtl/frame_timing_ctrl_if.sv
// frame_timing_ctrl_if: host request, custom staging, generator feedback and config bus bundle
// master: host/generator side driving requests, staging writes and v_sync
// slave: the controller driving ack/err/busy, generator reset, timing buses and locked
interface frame_timing_ctrl_if;
  logic        cfg_req;
  logic [2:0]  cfg_mode;
  logic        cfg_ack;
  logic        cfg_err;
  logic        cfg_busy;
  logic        cust_wr;
  logic [1:0]  cust_addr;
  logic [31:0] cust_data;
  logic        fg_v_sync;
  logic        fg_reset_n;
  logic [21:0] resolution;
  logic [31:0] Hfrporch_Vfrporch;
  logic [31:0] Hbkporch_Vbkporch;
  logic [31:0] Hsyncpulse_Vsyncpulse;
  logic        locked;
  modport master (
    output cfg_req, cfg_mode, cust_wr, cust_addr, cust_data, fg_v_sync,
    input  cfg_ack, cfg_err, cfg_busy, fg_reset_n, resolution,
           Hfrporch_Vfrporch, Hbkporch_Vbkporch, Hsyncpulse_Vsyncpulse, locked
  );
  modport slave (
    input  cfg_req, cfg_mode, cust_wr, cust_addr, cust_data, fg_v_sync,
    output cfg_ack, cfg_err, cfg_busy, fg_reset_n, resolution,
           Hfrporch_Vfrporch, Hbkporch_Vbkporch, Hsyncpulse_Vsyncpulse, locked
  );
endinterface

// File: rtl/timing_mode_rom.sv
// timing_mode_rom: combinational preset lookup from mode index to timing_t
// idx: preset index; t: timing words (unknown indices fall back to 640x480)
module timing_mode_rom import frame_timing_pkg::*; (
  input  logic [2:0] idx,
  output timing_t    t
);
  assign t = idx == 3'd1 ? MODE_800X600 :
             idx == 3'd2 ? MODE_1024X768 :
             idx == 3'd3 ? MODE_1280X1024 : MODE_640X480;
endmodule

// File: rtl/frame_timing_ctrl.sv
// frame_timing_ctrl: applies timing-mode changes to the frame generator at frame boundaries
// clk: pixel clock; reset: async active-low; bus (slave): cfg handshake, custom staging,
// generator v_sync in, generator reset/config buses/locked out.
// FRAME_TIMING_CUSTOM_EN: builds the custom staging registers and makes mode 7 legal.
module frame_timing_ctrl import frame_timing_pkg::*; #(
  parameter int NUM_MODES     = 4,
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_FRAMES = 2,
  parameter int VS_TIMEOUT    = 4194304
) (
  input logic clk,
  input logic reset,
  frame_timing_ctrl_if.slave bus
);
  localparam int TW = $clog2(VS_TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  state_t state;
  timing_t rom_t, sel, pend, cur;
  bus_t words;
  logic vs_q, vs_p, fall, armed, boot, sel_ok, unused_cust;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic [SW-1:0] scnt;
  timing_mode_rom u_rom (.idx(bus.cfg_mode), .t(rom_t));
  assign unused_cust = ^{bus.cust_wr, bus.cust_addr, bus.cust_data};
`ifdef FRAME_TIMING_CUSTOM_EN
  timing_t stg;
  always_ff @(posedge clk or negedge reset)
    if (!reset) stg <= '0;
    else if (bus.cust_wr) begin
      if (bus.cust_addr == 2'd0) {stg.width, stg.height} <= bus.cust_data[21:0];
      if (bus.cust_addr == 2'd1) {stg.h_front, stg.v_front} <= {bus.cust_data[24:16], bus.cust_data[5:0]};
      if (bus.cust_addr == 2'd2) {stg.h_back, stg.v_back} <= {bus.cust_data[24:16], bus.cust_data[7:0]};
      if (bus.cust_addr == 2'd3) {stg.h_sync, stg.v_sync} <= {bus.cust_data[24:16], bus.cust_data[5:0]};
    end
  assign sel = bus.cfg_mode == 3'd7 ? stg : rom_t;
  assign sel_ok = int'(bus.cfg_mode) < NUM_MODES ||
                  (bus.cfg_mode == 3'd7 && stg.width != '0 && stg.height != '0);
`else
  assign sel = rom_t;
  assign sel_ok = int'(bus.cfg_mode) < NUM_MODES;
`endif
  // falling edge of the once-registered v_sync marks a frame boundary
  assign fall = vs_p & ~vs_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state          <= HOLD;
      pend           <= MODE_640X480;
      cur            <= MODE_640X480;
      vs_q           <= 1'b1;
      vs_p           <= 1'b1;
      armed          <= 1'b0;
      boot           <= 1'b1;
      tcnt           <= '0;
      hcnt           <= '0;
      scnt           <= '0;
      bus.fg_reset_n <= 1'b0;
      bus.locked     <= 1'b0;
      bus.cfg_busy   <= 1'b1;
      bus.cfg_ack    <= 1'b0;
      bus.cfg_err    <= 1'b0;
    end else begin
      vs_q        <= bus.fg_v_sync;
      vs_p        <= vs_q;
      bus.cfg_ack <= 1'b0;
      bus.cfg_err <= 1'b0;
      if (!bus.cfg_req) armed <= 1'b1;
      case (state)
        IDLE: if (bus.cfg_req && armed) begin
          armed <= 1'b0;
          boot  <= 1'b0;
          // a rejected request never disturbs locked/busy, so they read as unchanged
          if (sel_ok) begin
            pend         <= sel;
            bus.locked   <= 1'b0;
            bus.cfg_busy <= 1'b1;
            tcnt         <= '0;
            state        <= WAIT_VS;
          end else begin
            bus.cfg_ack <= 1'b1;
            bus.cfg_err <= 1'b1;
          end
        end
        WAIT_VS: if (fall || tcnt == TW'(VS_TIMEOUT - 1)) begin
          cur            <= pend;
          bus.fg_reset_n <= 1'b0;
          hcnt           <= '0;
          state          <= HOLD;
        end else tcnt <= tcnt + 1'b1;
        HOLD: if (hcnt == HW'(HOLD_CYCLES - 1)) begin
          bus.fg_reset_n <= 1'b1;
          scnt           <= '0;
          state          <= SETTLE;
        end else hcnt <= hcnt + 1'b1;
        SETTLE: if (fall) begin
          if (scnt == SW'(SETTLE_FRAMES - 1)) begin
            bus.locked   <= 1'b1;
            bus.cfg_busy <= 1'b0;
            bus.cfg_ack  <= ~boot;
            state        <= IDLE;
          end else scnt <= scnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  assign words                     = pack_timing(cur);
  assign bus.resolution            = words.res;
  assign bus.Hfrporch_Vfrporch     = words.front;
  assign bus.Hbkporch_Vbkporch     = words.back;
  assign bus.Hsyncpulse_Vsyncpulse = words.sync;
endmodule
